dmem_responder: RTL
===================

# dmem_responder

Word-addressed data-memory responder that services load/store requests from the processor core's data-memory port over a valid/ready request and response handshake. It holds the data array and inserts a fixed, parameterised number of wait states before each access. It returns one response per request: read data for loads, a completion acknowledge for stores. It sits between the processor datapath's memory stage and the data storage, and replaces the core's internal data array.

## Interface

- `ADDR_W`, 5: index width; depth = 2^ADDR_W words.
- `DATA_W`, 32: word width.
- `WAIT_CYCLES`, 2: wait states inserted between request acceptance and the access; legal range 0..15.

- `clk`  in  1  single clock; all state is updated on the rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  word address.
- `req_wdata`  in  DATA_W  store data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  requester can take the response.
- `rsp_rdata`  out  DATA_W  load data; 0 for stores and errors.
- `rsp_err`  out  1  address error; see Configuration.
- `busy`  out  1  a transaction is in flight, i.e. state is not IDLE.

## Operation

- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready` = 1.
  - When `req_valid` & `req_ready` are both 1 at an edge, latch `req_write`, `req_addr` and `req_wdata`, and load the wait counter with WAIT_CYCLES.
  - If WAIT_CYCLES = 0, go to RESP. Otherwise go to WAIT.
- **WAIT**
  - `req_ready` = 0.
  - The counter decrements by 1 each edge.
  - On the edge where the counter is 1, go to RESP.
- **Access**
  - The access is performed on the edge that enters RESP.
  - Store: mem[addr] <= wdata, and `rsp_rdata` <= 0.
  - Load: `rsp_rdata` <= mem[addr].
  - On the same edge, `rsp_err` is computed and registered.
- **RESP**
  - `rsp_valid` = 1.
  - `rsp_rdata` and `rsp_err` stay stable until `rsp_valid` & `rsp_ready` are both 1 at an edge.
  - On that edge, go to IDLE, and `rsp_valid`, `rsp_rdata` and `rsp_err` clear to 0.
- **Request inputs outside IDLE**: ignored. They are not acknowledged and not queued.
- **Addressing**: `req_addr` is a word index, with no byte lanes. The index used is `req_addr[ADDR_W-1:0]`, subject to the error check.
- **Reset values**
  - `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, `busy` = 0.
  - State = IDLE, counter = 0.
- **Memory contents** are not reset.
- **Reset mid-operation**: the in-flight transaction is dropped. A store that has not yet reached the access edge is not committed. A store whose access edge has already occurred remains committed.
- **Consecutive transactions**: a store followed by a load to the same address returns the stored value. Transactions are strictly sequential, so no forwarding is needed.

## Timing

- Let E0 be the acceptance edge.
- The access happens at edge E0 + WAIT_CYCLES (the acceptance edge itself when WAIT_CYCLES = 0).
- `rsp_valid` first becomes 1 in the cycle after that access edge. Load-to-use latency is therefore WAIT_CYCLES + 1 cycles.
- With `rsp_ready` held at 1, the minimum spacing between accepted requests is WAIT_CYCLES + 2 cycles.
- `req_ready` comes from the state register only, with no combinational path from `req_valid`.
- `rsp_valid` comes from the state register only, with no combinational path from `rsp_ready`.
- `busy` = (state != IDLE).

## Configuration

- Macro: `DMEM_ADDR_CHECK_EN`.
- **Defined**
  - If any bit of `req_addr[31:ADDR_W]` is set, the transaction is out of range.
  - Out-of-range transactions: stores are suppressed (memory is unchanged), and `rsp_rdata` = 0, `rsp_err` = 1.
  - Timing is identical to an in-range access.
- **Undefined**
  - Upper address bits are ignored, so addresses wrap modulo 2^ADDR_W.
  - `rsp_err` is tied to 0.
  - No check logic is synthesised.

## Test plan

- **Reset state**: hold `resetn` = 0, then release. Required: `req_ready` = 1, `rsp_valid` = 0, `busy` = 0, `rsp_err` = 0. Then assert reset asynchronously mid-cycle: outputs return to these values immediately, without waiting for a clock edge.
- **Store then load, default WAIT_CYCLES = 2, `rsp_ready` = 1**
  - Store 0xDEADBEEF to address 5: `rsp_valid` is high 3 cycles after acceptance and `rsp_rdata` = 0.
  - Load from address 5: `rsp_rdata` = 0xDEADBEEF, and `rsp_valid` is high 3 cycles after acceptance.
- **Backpressure**: load address 5 with `rsp_ready` = 0 for 4 cycles. Required: `rsp_valid` and `rsp_rdata` = 0xDEADBEEF stay stable and `req_ready` = 0 throughout. Then set `rsp_ready` = 1: one handshake, return to IDLE, and the next request is accepted one cycle later.
- **WAIT_CYCLES = 0**: load address 5 (after storing 0xDEADBEEF there). Required: `rsp_valid` rises the cycle after acceptance. A stream of 4 back-to-back loads with `rsp_ready` = 1 completes in 8 cycles.
- **Address error**
  - Store 0x12345678 to address 0x25 (ADDR_W = 5), then load address 5.
  - With `DMEM_ADDR_CHECK_EN` defined: the store gives `rsp_err` = 1, and the load returns the unchanged 0xDEADBEEF.
  - Without it: the store aliases to address 5 with `rsp_err` = 0, and the load returns 0x12345678.
- **Reset mid-operation**: accept a store of 0xCAFEF00D to address 7 (WAIT_CYCLES = 2), then pulse `resetn` low 1 cycle after acceptance. Required: no response. A subsequent load from address 7 returns its prior value, not 0xCAFEF00D.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory behind a valid/ready request
// and response handshake. Each access is preceded by WAIT_CYCLES wait states.
// Optional feature: define DMEM_ADDR_CHECK_EN to flag any request with a set
// bit in req_addr[31:ADDR_W] as an error and suppress its store. When it is
// undefined, the upper address bits are ignored and addresses wrap.
//
// state | meaning
// IDLE  | ready for a request; req_ready = 1
// WAIT  | request latched; counting down the wait states
// RESP  | access done; response held until rsp_ready
module dmem_responder #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                oor_q;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   mem_q [2**ADDR_W];

    logic                accept;
    logic                access;
    logic                req_oor;
    logic                acc_wr;
    logic                acc_oor;
    logic [ADDR_W-1:0]   acc_idx;
    logic [DATA_W-1:0]   acc_wdata;

`ifdef DMEM_ADDR_CHECK_EN
    assign req_oor = |req_addr[31:ADDR_W];
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W];
    assign req_oor        = 1'b0;
`endif

    // With zero wait states the access happens on the acceptance edge, so the
    // access operands come straight from the request inputs while in IDLE.
    assign acc_wr    = (state_q == IDLE) ? req_write                : wr_q;
    assign acc_idx   = (state_q == IDLE) ? req_addr[ADDR_W-1:0]     : addr_q;
    assign acc_wdata = (state_q == IDLE) ? req_wdata                : wdata_q;
    assign acc_oor   = (state_q == IDLE) ? req_oor                  : oor_q;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Next-state, wait counter and response data selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    cnt_d  = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    access  = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (access) begin
            rdata_d = (acc_wr || acc_oor) ? '0 : mem_q[acc_idx];
            err_d   = acc_oor;
        end
    end

    // State, counter, latched request and registered response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            oor_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr[ADDR_W-1:0];
                wdata_q <= req_wdata;
                oor_q   <= req_oor;
            end
        end
    end

    // Storage array; not reset. Out-of-range stores never commit.
    always_ff @(posedge clk) begin
        if (access && acc_wr && !acc_oor) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

endmodule
